key_compare_pipe: RTL and testbench
===================================

Name: key_compare_pipe

Overview:
Parametrised, pipelined successor to the combinational XNOR2/AND4 key comparator. It accepts one key attempt at a time over a valid/ready handshake and compares it bitwise against a reference key. The per-bit matches go through a registered AND-4 reduction tree, and the block reports a one-cycle match result. A failed-attempt counter drives a timed lockout FSM, and the block sits between the Sentinel input front-end and the unlock controller.

Parameters:
KEY_W, 32, key width in bits (>=2)
MAX_FAILS, 3, consecutive mismatches that trigger lockout (>=1)
LOCK_CYCLES, 256, lockout duration in clk cycles (>=1)

Ports:
clk  in  1  system clock, all state on posedge
r  in  1  asynchronous active-high reset
in_valid  in  1  attempt presented
in_ready  out  1  block can accept an attempt
in_key  in  KEY_W  attempted key
ref_key  in  KEY_W  reference key, sampled with the attempt
clr_fails  in  1  synchronous admin clear of fail count and lockout
res_valid  out  1  one-cycle pulse, result available
res_match  out  1  1 = keys equal; valid only while res_valid=1
locked  out  1  lockout active
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive mismatch count

Behaviour:
- Clock/reset: one clock, clk. Reset r is asynchronous and active-high.
- Reset values: in_ready=1, res_valid=0, res_match=0, locked=0, fail_cnt=0. FSM=READY, all pipeline valid bits=0, lock timer=0.
- FSM states: READY, CHECK, LOCKOUT.
- Accept: handshake fires when in_valid & in_ready. in_ready=1 only in READY.
  - On accept, register in_key XNOR ref_key into stage 0 and move to CHECK. in_ready drops the next cycle.
- Reduction: stage 0 vector is padded to a multiple of 4 with 1s. Each following stage registers the AND of groups of 4 from the previous stage, until one bit remains.
  - Stages S = ceil(log4(KEY_W)), minimum 1.
  - Latency L = 1+S cycles from the accept edge to res_valid=1. Example: KEY_W=32 gives L=4; KEY_W=10 gives L=3.
- Result: res_valid pulses for exactly one cycle, and res_match is registered alongside it.
  - On match: fail_cnt is cleared to 0 and the FSM returns to READY.
  - On mismatch: fail_cnt increments. If the new value equals MAX_FAILS, go to LOCKOUT. Otherwise return to READY.
  - in_ready rises in the cycle after res_valid.
- LOCKOUT:
  - Entry sets locked=1 and loads the timer with LOCK_CYCLES-1. The timer decrements each cycle.
  - When the timer reaches 0: locked=0, fail_cnt=0, state=READY.
  - locked is high for exactly LOCK_CYCLES cycles, and in_ready stays 0 for that period.
- clr_fails:
  - In LOCKOUT or READY: clears fail_cnt and the timer, and sets state=READY on the next edge.
  - In CHECK: clears fail_cnt immediately. The in-flight result is still reported, and its own increment/lockout rule applies after the clear.
- in_valid outside READY is ignored; no buffering.
- fail_cnt saturates at MAX_FAILS and never wraps.
- Reset mid-CHECK or mid-LOCKOUT aborts immediately. No res_valid is emitted afterwards.

Decomposition:
- Package citadel_pkg holds:
  - the enum key_state_t {READY, CHECK, LOCKOUT};
  - the function stages_for(width), ceil log4 with minimum 1;
  - the function pad4(width).
- Sub-module and4_reduce_stage (parameter IN_W) implements one registered AND-4 tree level plus its valid bit, with async reset r. It is generate-instantiated S times.
- The FSM, counter and timer live in the top module.

Test Plan:
- Assert r mid-cycle, then release -> all outputs at reset values immediately; in_ready=1 on the first clk.
- KEY_W=32, in_key=ref_key=32'hDEADBEEF, accepted at edge 0 -> res_valid=1 and res_match=1 at edge 4 only; fail_cnt=0; in_ready=1 at edge 5.
- in_key=32'hDEADBEEE vs ref 32'hDEADBEEF -> res_match=0, fail_cnt=1. Then a matching attempt -> fail_cnt=0.
- Three consecutive mismatches (MAX_FAILS=3, LOCK_CYCLES=256) -> locked=1 for exactly 256 cycles, in_ready=0 throughout, in_valid ignored. After that: locked=0, fail_cnt=0, in_ready=1.
- clr_fails pulsed at lockout cycle 10 -> locked=0, fail_cnt=0, in_ready=1 the next cycle.
- KEY_W=10, keys differ only in bit 9 -> res_match=0 at L=3; equal keys -> res_match=1, confirming padding. Also r asserted during CHECK -> no res_valid ever emitted for that attempt.

Source files
------------

// File: rtl/citadel_pkg.sv
// Shared types and elaboration helpers for the key comparator.
// Sizing functions are evaluated at elaboration time only.
package citadel_pkg;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        CHECK   = 2'd1,
        LOCKOUT = 2'd2
    } key_state_t;

    // Number of AND-4 levels needed to fold width bits to one (ceil log4, min 1).
    function automatic int stages_for(input int width);
        int s;
        int span;
        s    = 1;
        span = 4;
        while (span < width) begin
            span = span * 4;
            s    = s + 1;
        end
        return s;
    endfunction

    // Width rounded up to the next multiple of 4.
    function automatic int pad4(input int width);
        return ((width + 3) / 4) * 4;
    endfunction

    // Vector width seen at the input of reduction level lvl.
    function automatic int level_w(input int width, input int lvl);
        int w;
        w = width;
        for (int i = 0; i < lvl; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

endpackage

// File: rtl/and4_reduce_stage.sv
// One registered level of the AND-4 match reduction tree.
// Short inputs are padded with 1s so they never mask a mismatch.
module and4_reduce_stage #(
    parameter int IN_W = 4
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic [IN_W-1:0]          d,
    input  logic                     d_valid,
    output logic [(IN_W+3)/4-1:0]    q,
    output logic                     q_valid
);

    localparam int OUT_W = (IN_W + 3) / 4;
    localparam int PAD_W = OUT_W * 4;

    logic [PAD_W-1:0] pd;

    // Pad the input up to whole groups of four with neutral 1s.
    always_comb begin
        pd           = '1;
        pd[IN_W-1:0] = d;
    end

    // Register the AND of each group of four and carry the valid bit along.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= d_valid;
            for (int i = 0; i < OUT_W; i++) begin
                q[i] <= &pd[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/key_compare_pipe.sv
// Pipelined key comparator with fail counting and timed lockout.
// Bitwise XNOR is registered, folded by AND-4 stages, then reported.
module key_compare_pipe
    import citadel_pkg::*;
#(
    parameter int KEY_W       = 32,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 256
) (
    input  logic                               clk,
    input  logic                               r,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [KEY_W-1:0]                   in_key,
    input  logic [KEY_W-1:0]                   ref_key,
    input  logic                               clr_fails,
    output logic                               res_valid,
    output logic                               res_match,
    output logic                               locked,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

    localparam int S  = stages_for(KEY_W);
    localparam int P0 = pad4(KEY_W);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(LOCK_CYCLES + 1);

    localparam logic [FW-1:0] MAXF      = FW'(MAX_FAILS);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

    key_state_t       state;
    logic [TW-1:0]    timer;
    logic [P0-1:0]    xn;
    logic [P0-1:0]    s0_vec;
    logic             s0_valid;
    logic             last_q;
    logic             last_v;
    logic             accept;
    logic [FW-1:0]    cnt_base;
    logic [FW-1:0]    cnt_inc;

    assign accept = in_valid & in_ready;

    // Per-bit equality, padded with 1s up to a multiple of four.
    always_comb begin
        xn            = '1;
        xn[KEY_W-1:0] = ~(in_key ^ ref_key);
    end

    // Stage 0 captures the per-bit match vector on an accepted attempt.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            s0_vec   <= '1;
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_vec <= xn;
            end
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_lvl
        localparam int IW = level_w(P0, k);
        localparam int OW = (IW + 3) / 4;
        logic [OW-1:0] q;
        logic          v;
        if (k == 0) begin : g_first
            and4_reduce_stage #(
                .IN_W(IW)
            ) u_stage (
                .clk     (clk),
                .r       (r),
                .d       (s0_vec),
                .d_valid (s0_valid),
                .q       (q),
                .q_valid (v)
            );
        end else begin : g_next
            and4_reduce_stage #(
                .IN_W(IW)
            ) u_stage (
                .clk     (clk),
                .r       (r),
                .d       (g_lvl[k-1].q),
                .d_valid (g_lvl[k-1].v),
                .q       (q),
                .q_valid (v)
            );
        end
    end

    assign last_q = g_lvl[S-1].q[0];
    assign last_v = g_lvl[S-1].v;

    // Register the final tree output as a one-cycle result pulse.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            res_valid <= 1'b0;
            res_match <= 1'b0;
        end else begin
            res_valid <= last_v;
            res_match <= last_v & last_q;
        end
    end

    // Admin clear in flight wins over the old count; increment saturates.
    always_comb begin
        cnt_base = clr_fails ? '0 : fail_cnt;
        cnt_inc  = (cnt_base == MAXF) ? cnt_base : cnt_base + FW'(1);
    end

    // Attempt FSM with fail counter, lockout timer and registered outputs.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state    <= READY;
            in_ready <= 1'b1;
            locked   <= 1'b0;
            fail_cnt <= '0;
            timer    <= '0;
        end else begin
            unique case (state)
                READY: begin
                    if (clr_fails) begin
                        fail_cnt <= '0;
                        timer    <= '0;
                    end
                    if (accept) begin
                        state    <= CHECK;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    in_ready <= 1'b0;
                    if (last_v) begin
                        if (last_q) begin
                            fail_cnt <= '0;
                            state    <= READY;
                        end else begin
                            fail_cnt <= cnt_inc;
                            if (cnt_inc == MAXF) begin
                                state  <= LOCKOUT;
                                locked <= 1'b1;
                                timer  <= LOCK_LOAD;
                            end else begin
                                state <= READY;
                            end
                        end
                    end else if (clr_fails) begin
                        fail_cnt <= '0;
                    end
                end
                LOCKOUT: begin
                    if (clr_fails || timer == '0) begin
                        state    <= READY;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                        timer    <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state    <= READY;
                    in_ready <= 1'b1;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_compare_pipe.sv
// Directed and randomized checks of key_compare_pipe at two widths.
// Expected values come from a behavioural model of attempts and fails.
module tb_key_compare_pipe;

    localparam int MAXA  = 3;
    localparam int LOCKA = 256;
    localparam int MAXB  = 2;
    localparam int LOCKB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fa = 0;
    int fb = 0;

    logic        a_r, a_iv, a_ir, a_clr, a_rv, a_rm, a_lk;
    logic [31:0] a_k, a_rk;
    logic [1:0]  a_fc;

    logic        b_r, b_iv, b_ir, b_clr, b_rv, b_rm, b_lk;
    logic [9:0]  b_k, b_rk;
    logic [1:0]  b_fc;

    key_compare_pipe #(
        .KEY_W(32), .MAX_FAILS(MAXA), .LOCK_CYCLES(LOCKA)
    ) dut_a (
        .clk(clk), .r(a_r), .in_valid(a_iv), .in_ready(a_ir),
        .in_key(a_k), .ref_key(a_rk), .clr_fails(a_clr),
        .res_valid(a_rv), .res_match(a_rm), .locked(a_lk),
        .fail_cnt(a_fc)
    );

    key_compare_pipe #(
        .KEY_W(10), .MAX_FAILS(MAXB), .LOCK_CYCLES(LOCKB)
    ) dut_b (
        .clk(clk), .r(b_r), .in_valid(b_iv), .in_ready(b_ir),
        .in_key(b_k), .ref_key(b_rk), .clr_fails(b_clr),
        .res_valid(b_rv), .res_match(b_rm), .locked(b_lk),
        .fail_cnt(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One attempt on the 32-bit unit; model decides match, count, lockout.
    task automatic run_a(input logic [31:0] k, input logic [31:0] rf,
                         input bit clr_chk, input int clr_lock);
        bit exp_m;
        bit lock;
        bit bad;
        int n;
        exp_m = (k == rf);
        @(negedge clk);
        chk("a_ready_pre", a_ir, 1);
        a_k  = k;
        a_rk = rf;
        a_iv = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        a_k  = $urandom;
        a_rk = $urandom;
        chk("a_ready_drop", a_ir, 0);
        chk("a_valid_e0", a_rv, 0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk("a_valid_early", a_rv, 0);
            if (clr_chk && i == 1) a_clr = 1'b1;
            if (clr_chk && i == 2) begin
                a_clr = 1'b0;
                fa = 0;
                chk("a_clr_check_cnt", a_fc, 0);
            end
        end
        @(posedge clk); #1;
        if (exp_m) fa = 0;
        else if (fa < MAXA) fa = fa + 1;
        lock = (fa == MAXA);
        chk("a_valid_l4", a_rv, 1);
        chk("a_match", a_rm, exp_m);
        chk("a_fail_cnt", a_fc, fa);
        if (!lock) begin
            @(posedge clk); #1;
            chk("a_valid_drop", a_rv, 0);
            chk("a_ready_back", a_ir, 1);
        end else begin
            a_iv = 1'b1;
            a_k  = 32'h1234;
            a_rk = 32'h1234;
            n = 0;
            bad = 0;
            if (clr_lock > 0) begin
                for (int i = 0; i < clr_lock; i++) begin
                    if (!a_lk || a_ir) bad = 1;
                    @(posedge clk); #1;
                end
                a_clr = 1'b1;
                @(posedge clk); #1;
                a_clr = 1'b0;
                a_iv  = 1'b0;
                chk("a_clr_lock_hold", bad, 0);
            end else begin
                while (a_lk && n < 400) begin
                    n++;
                    if (a_ir) bad = 1;
                    if (n > 1 && a_rv) bad = 1;
                    @(posedge clk); #1;
                end
                a_iv = 1'b0;
                chk("a_lock_len", n, LOCKA);
                chk("a_lock_hold", bad, 0);
            end
            fa = 0;
            chk("a_unlocked", a_lk, 0);
            chk("a_unlock_cnt", a_fc, 0);
            chk("a_unlock_ready", a_ir, 1);
        end
    endtask

    // One attempt on the 10-bit unit (three-cycle latency).
    task automatic run_b(input logic [9:0] k, input logic [9:0] rf);
        bit exp_m;
        bit bad;
        int n;
        exp_m = (k == rf);
        @(negedge clk);
        chk("b_ready_pre", b_ir, 1);
        b_k  = k;
        b_rk = rf;
        b_iv = 1'b1;
        @(posedge clk); #1;
        b_iv = 1'b0;
        b_k  = 10'($urandom);
        b_rk = 10'($urandom);
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b_valid_early", b_rv, 0);
        end
        @(posedge clk); #1;
        if (exp_m) fb = 0;
        else if (fb < MAXB) fb = fb + 1;
        chk("b_valid_l3", b_rv, 1);
        chk("b_match", b_rm, exp_m);
        chk("b_fail_cnt", b_fc, fb);
        if (fb == MAXB) begin
            n = 0;
            bad = 0;
            while (b_lk && n < 50) begin
                n++;
                if (b_ir) bad = 1;
                @(posedge clk); #1;
            end
            fb = 0;
            chk("b_lock_len", n, LOCKB);
            chk("b_lock_hold", bad, 0);
            chk("b_unlock_ready", b_ir, 1);
        end else begin
            @(posedge clk); #1;
            chk("b_ready_back", b_ir, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rf32;
        logic [31:0] k32;
        logic [9:0]  rf10;
        logic [9:0]  k10;
        bit          bad;

        a_r = 0; a_iv = 0; a_clr = 0; a_k = '0; a_rk = '0;
        b_r = 0; b_iv = 0; b_clr = 0; b_k = '0; b_rk = '0;

        #2;
        a_r = 1'b1;
        b_r = 1'b1;
        #1;
        chk("rst_ready", a_ir, 1);
        chk("rst_valid", a_rv, 0);
        chk("rst_match", a_rm, 0);
        chk("rst_locked", a_lk, 0);
        chk("rst_cnt", a_fc, 0);
        chk("rst_b_ready", b_ir, 1);
        @(negedge clk);
        a_r = 1'b0;
        b_r = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_clk1", a_ir, 1);

        run_a(32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        run_a(32'hDEADBEEE, 32'hDEADBEEF, 0, 0);
        run_a(32'hDEADBEEF, 32'hDEADBEEF, 0, 0);

        for (int i = 0; i < 3; i++) run_a(32'h0, 32'h8000_0000, 0, 0);

        run_a(32'h1, 32'h0, 0, 0);
        run_a(32'h2, 32'h0, 0, 0);
        run_a(32'h4, 32'h0, 0, 10);

        run_a(32'h10, 32'h0, 0, 0);
        run_a(32'h20, 32'h0, 1, 0);
        run_a(32'h40, 32'h0, 0, 0);
        run_a(32'hCAFE, 32'hCAFE, 0, 0);

        for (int i = 0; i < 8; i++) begin
            rf32 = $urandom;
            k32  = rf32;
            if ($urandom_range(0, 1) == 1)
                k32 = rf32 ^ (32'h1 << $urandom_range(0, 31));
            run_a(k32, rf32, 0, 0);
        end

        run_b(10'h2A5, 10'h2A5);
        run_b(10'h0A5, 10'h2A5);
        run_b(10'h3FF, 10'h3FF);
        run_b(10'h000, 10'h001);
        run_b(10'h1FF, 10'h3FF);

        for (int i = 0; i < 8; i++) begin
            rf10 = 10'($urandom);
            k10  = rf10;
            if ($urandom_range(0, 1) == 1)
                k10 = rf10 ^ (10'h1 << $urandom_range(0, 9));
            run_b(k10, rf10);
        end

        @(negedge clk);
        b_k  = 10'h155;
        b_rk = 10'h155;
        b_iv = 1'b1;
        @(posedge clk); #1;
        b_iv = 1'b0;
        @(posedge clk);
        #2;
        b_r = 1'b1;
        #1;
        fb = 0;
        chk("b_rst_valid", b_rv, 0);
        chk("b_rst_ready", b_ir, 1);
        chk("b_rst_cnt", b_fc, 0);
        chk("b_rst_locked", b_lk, 0);
        @(negedge clk);
        b_r = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (b_rv) bad = 1;
        end
        chk("b_rst_no_result", bad, 0);
        run_b(10'h155, 10'h155);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
